// File: rtl/io_out_bank.sv
// Output port bank: bytes are staged over a strobe bus, then a commit copies all staging
// registers to the visible ports at once. Masked ports blink off with a divided clock.
module io_out_bank #(
  parameter int BLINK_DIV = 25_000_000,
  parameter int CNT_W     = 25
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [2:0] ADDR,
  input  logic [7:0] WDATA,
  input  logic       WEN,
  input  logic       COMMIT,
  output logic [7:0] RDATA,
  output logic       PENDING,
  output logic [7:0] IOD,
  output logic [7:0] IOE,
  output logic [7:0] IOF,
  output logic [7:0] IOG,
  output logic       BLINK_PH
);

  logic [7:0]       stage      [0:3];
  logic [3:0]       stage_mask;
  logic [7:0]       vis        [0:3];
  logic [3:0]       vis_mask;
  logic [7:0]       io         [0:3];
  logic [CNT_W-1:0] cnt;

  logic [7:0]       vis_next   [0:3];
  logic [3:0]       mask_next;
  logic [7:0]       rd_next;
  logic             wr_valid;

  assign wr_valid = WEN && (ADDR <= 3'd4);

  // Commit uses the staging contents from before this edge, so a same-edge write only
  // lands in staging and is picked up by the next commit.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      vis_next[i] = COMMIT ? stage[i] : vis[i];
    end
    mask_next = COMMIT ? stage_mask : vis_mask;
    rd_next   = 8'h00;
    if (ADDR == 3'd4) begin
      rd_next = {4'b0000, stage_mask};
    end else if (ADDR < 3'd4) begin
      rd_next = stage[ADDR[1:0]];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) begin
        stage[i] <= 8'h00;
        vis[i]   <= 8'h00;
        io[i]    <= 8'h00;
      end
      stage_mask <= 4'h0;
      vis_mask   <= 4'h0;
      cnt        <= '0;
      BLINK_PH   <= 1'b1;
      PENDING    <= 1'b0;
      RDATA      <= 8'h00;
    end else begin
      if (cnt == CNT_W'(BLINK_DIV - 1)) begin
        cnt      <= '0;
        BLINK_PH <= ~BLINK_PH;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (wr_valid) begin
        if (ADDR == 3'd4) begin
          stage_mask <= WDATA[3:0];
        end else begin
          stage[ADDR[1:0]] <= WDATA;
        end
        PENDING <= 1'b1;
      end else if (COMMIT) begin
        PENDING <= 1'b0;
      end

      RDATA    <= rd_next;
      vis_mask <= mask_next;
      // Gating sees the phase held before this edge, giving the one-cycle lag on BLINK_PH.
      for (int i = 0; i < 4; i++) begin
        vis[i] <= vis_next[i];
        io[i]  <= (mask_next[i] && !BLINK_PH) ? 8'h00 : vis_next[i];
      end
    end
  end

  assign IOD = io[0];
  assign IOE = io[1];
  assign IOF = io[2];
  assign IOG = io[3];

endmodule

// File: tb/tb_io_out_bank.sv
// Randomised and directed bench for io_out_bank, checked every cycle against a
// register-file model whose blink phase is derived from edges elapsed since reset.
module tb_io_out_bank;

  localparam int BLINK_DIV = 4;

  logic       CLK;
  logic       RESET;
  logic [2:0] ADDR;
  logic [7:0] WDATA;
  logic       WEN;
  logic       COMMIT;
  logic [7:0] RDATA;
  logic       PENDING;
  logic [7:0] IOD, IOE, IOF, IOG;
  logic       BLINK_PH;

  int total = 0;
  int bad   = 0;

  io_out_bank #(.BLINK_DIV(BLINK_DIV), .CNT_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .WDATA(WDATA), .WEN(WEN), .COMMIT(COMMIT),
    .RDATA(RDATA), .PENDING(PENDING), .IOD(IOD), .IOE(IOE), .IOF(IOF), .IOG(IOG),
    .BLINK_PH(BLINK_PH)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- reference model ----------------
  logic [7:0] m_stage [0:4];
  logic [7:0] m_vis   [0:4];
  logic [7:0] m_io    [0:3];
  logic [7:0] m_rdata;
  logic       m_pend;
  logic       m_valid = 1'b0;
  int         m_k;

  function automatic logic phase_at(input int k);
    return ((k / BLINK_DIV) % 2) == 0;
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 5; i++) begin
        m_stage[i] = 8'h00;
        m_vis[i]   = 8'h00;
      end
      for (int i = 0; i < 4; i++) m_io[i] = 8'h00;
      m_rdata = 8'h00;
      m_pend  = 1'b0;
      m_k     = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      logic ph_before;
      ph_before = phase_at(m_k);
      m_k++;
      m_rdata = (ADDR <= 3'd4) ? m_stage[ADDR] : 8'h00;
      if (COMMIT) begin
        for (int i = 0; i < 5; i++) m_vis[i] = m_stage[i];
      end
      for (int i = 0; i < 4; i++) begin
        m_io[i] = (m_vis[4][i] && !ph_before) ? 8'h00 : m_vis[i];
      end
      if (WEN && ADDR <= 3'd4) begin
        m_stage[ADDR] = (ADDR == 3'd4) ? (WDATA & 8'h0F) : WDATA;
        m_pend = 1'b1;
      end else if (COMMIT) begin
        m_pend = 1'b0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q [$];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %02h want %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (m_valid) begin
      check("model_rdata",   RDATA,            m_rdata);
      check("model_pending", {7'd0, PENDING},  {7'd0, m_pend});
      check("model_blink",   {7'd0, BLINK_PH}, {7'd0, phase_at(m_k)});
      check("model_iod",     IOD,              m_io[0]);
      check("model_ioe",     IOE,              m_io[1]);
      check("model_iof",     IOF,              m_io[2]);
      check("model_iog",     IOG,              m_io[3]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    ADDR = a; WDATA = d; WEN = 1'b1;
    tick();
    WEN = 1'b0;
  endtask

  task automatic do_commit();
    COMMIT = 1'b1;
    tick();
    COMMIT = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int off_cnt;
    int waited;
    RESET = 1'b1; WEN = 1'b1; COMMIT = 1'b1; ADDR = 3'd0; WDATA = 8'hFF;
    tick();
    tick();
    check("rst_iod", IOD, 8'h00);
    check("rst_ioe", IOE, 8'h00);
    check("rst_iof", IOF, 8'h00);
    check("rst_iog", IOG, 8'h00);
    check("rst_pending", {7'd0, PENDING}, 8'h00);
    check("rst_blink", {7'd0, BLINK_PH}, 8'h01);
    RESET = 1'b0; WEN = 1'b0; COMMIT = 1'b0;

    // staged writes stay invisible until commit
    do_write(3'd0, 8'hA5);
    do_write(3'd3, 8'h3C);
    check("wr_iod_hidden", IOD, 8'h00);
    check("wr_iog_hidden", IOG, 8'h00);
    check("wr_pending", {7'd0, PENDING}, 8'h01);
    do_commit();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    check("cm_iod", IOD, exp_q.pop_front());
    check("cm_iog", IOG, exp_q.pop_front());
    check("cm_ioe", IOE, 8'h00);
    check("cm_pending", {7'd0, PENDING}, 8'h00);

    // same-edge write and commit
    do_write(3'd1, 8'h11);
    do_commit();
    ADDR = 3'd1; WDATA = 8'h77; WEN = 1'b1; COMMIT = 1'b1;
    tick();
    WEN = 1'b0; COMMIT = 1'b0;
    check("same_ioe_old", IOE, 8'h11);
    check("same_pending", {7'd0, PENDING}, 8'h01);
    do_commit();
    check("same_ioe_new", IOE, 8'h77);

    // blink mask with upper bits dropped
    do_write(3'd4, 8'hF2);
    do_write(3'd1, 8'h55);
    do_commit();
    ADDR = 3'd4;
    tick();
    check("mask_readback", RDATA, 8'h02);
    off_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (IOE == 8'h00) off_cnt++;
      check("blink_iod_steady", IOD, 8'hA5);
    end
    check("blink_off_cycles", 8'(off_cnt), 8'd8);

    // unused address and read-during-write
    do_write(3'd6, 8'hFF);
    check("unused_pending", {7'd0, PENDING}, 8'h00);
    ADDR = 3'd6;
    tick();
    check("unused_rdata", RDATA, 8'h00);
    do_write(3'd0, 8'h9E);
    check("rdw_old", RDATA, 8'hA5);
    ADDR = 3'd0;
    tick();
    check("rdw_new", RDATA, 8'h9E);

    // reset during the off phase
    waited = 0;
    while (BLINK_PH !== 1'b0 && waited < 20) begin
      tick();
      waited++;
    end
    check("off_phase_reached", {7'd0, BLINK_PH}, 8'h00);
    RESET = 1'b1;
    tick();
    check("mid_rst_ioe", IOE, 8'h00);
    check("mid_rst_iod", IOD, 8'h00);
    check("mid_rst_blink", {7'd0, BLINK_PH}, 8'h01);
    RESET = 1'b0; ADDR = 3'd4;
    tick();
    check("mid_rst_mask", RDATA, 8'h00);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      ADDR   = 3'($urandom_range(0, 7));
      WDATA  = 8'($urandom_range(0, 255));
      WEN    = ($urandom_range(0, 1) == 1);
      COMMIT = ($urandom_range(0, 4) == 0);
      RESET  = ($urandom_range(0, 99) == 0);
      tick();
    end
    RESET = 1'b0; WEN = 1'b0; COMMIT = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
